// File: rtl/spin_phase_sampler.sv
// Ising spin readout: counts cell/reference phase disagreement over a fixed sample window.
// Optional build macro SAMPLER_GLITCH_FILTER_EN adds a 3-sample majority filter per input.
module spin_phase_sampler #(
    parameter int WINDOW_BITS   = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 ising_rstn,
    input  logic                 start,
    input  logic                 sin_ref,
    input  logic                 sin_cell,
    output logic                 busy,
    output logic                 valid,
    output logic                 spin,
    output logic [WINDOW_BITS:0] mismatch_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

    localparam logic [WINDOW_BITS:0] WINDOW_LEN = {1'b1, {WINDOW_BITS{1'b0}}};
    localparam logic [WINDOW_BITS:0] HALF_LEN   = WINDOW_LEN >> 1;
    localparam logic [WINDOW_BITS:0] CNT_ONE    = {{WINDOW_BITS{1'b0}}, 1'b1};
`ifdef SAMPLER_GLITCH_FILTER_EN
    localparam int SETTLE_LOAD = SETTLE_CYCLES + 1;
`else
    localparam int SETTLE_LOAD = SETTLE_CYCLES - 1;
`endif
    localparam logic [8:0] SETTLE_INIT = 9'(SETTLE_LOAD);

    logic [SYNC_STAGES-1:0] ref_sync;
    logic [SYNC_STAGES-1:0] cell_sync;
    logic                   sync_ref;
    logic                   sync_cell;
    logic                   ref_filt;
    logic                   cell_filt;
    logic                   mis;

    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) begin
            ref_sync  <= '0;
            cell_sync <= '0;
        end else begin
            ref_sync  <= {ref_sync[SYNC_STAGES-2:0], sin_ref};
            cell_sync <= {cell_sync[SYNC_STAGES-2:0], sin_cell};
        end
    end

    assign sync_ref  = ref_sync[SYNC_STAGES-1];
    assign sync_cell = cell_sync[SYNC_STAGES-1];

`ifdef SAMPLER_GLITCH_FILTER_EN
    logic [1:0] ref_hist;
    logic [1:0] cell_hist;

    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) begin
            ref_hist  <= '0;
            cell_hist <= '0;
        end else begin
            ref_hist  <= {ref_hist[0], sync_ref};
            cell_hist <= {cell_hist[0], sync_cell};
        end
    end

    // Majority of the current synchronized value and its two predecessors.
    assign ref_filt  = (sync_ref & ref_hist[0]) | (sync_ref & ref_hist[1]) |
                       (ref_hist[0] & ref_hist[1]);
    assign cell_filt = (sync_cell & cell_hist[0]) | (sync_cell & cell_hist[1]) |
                       (cell_hist[0] & cell_hist[1]);
`else
    assign ref_filt  = sync_ref;
    assign cell_filt = sync_cell;
`endif

    assign mis = ref_filt ^ cell_filt;

    state_t               state;
    state_t               state_d;
    logic [8:0]           settle_cnt;
    logic [8:0]           settle_d;
    logic [WINDOW_BITS:0] sample_cnt;
    logic [WINDOW_BITS:0] sample_d;
    logic [WINDOW_BITS:0] acc;
    logic [WINDOW_BITS:0] acc_d;
    logic [WINDOW_BITS:0] count_d;
    logic                 busy_d;
    logic                 valid_d;
    logic                 spin_d;

    always_ff @(posedge clk or negedge ising_rstn) begin
        if (!ising_rstn) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            sample_cnt     <= '0;
            acc            <= '0;
            busy           <= 1'b0;
            valid          <= 1'b0;
            spin           <= 1'b0;
            mismatch_count <= '0;
        end else begin
            state          <= state_d;
            settle_cnt     <= settle_d;
            sample_cnt     <= sample_d;
            acc            <= acc_d;
            busy           <= busy_d;
            valid          <= valid_d;
            spin           <= spin_d;
            mismatch_count <= count_d;
        end
    end

    // Outputs are registered from the next-state values, so valid lands one cycle after DONE is entered.
    always_comb begin
        state_d  = state;
        settle_d = settle_cnt;
        sample_d = sample_cnt;
        acc_d    = acc;
        busy_d   = busy;
        valid_d  = 1'b0;
        spin_d   = spin;
        count_d  = mismatch_count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    busy_d   = 1'b1;
                    settle_d = SETTLE_INIT;
                    acc_d    = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_d  = MEASURE;
                    sample_d = '0;
                end else begin
                    settle_d = settle_cnt - 9'd1;
                end
            end
            MEASURE: begin
                acc_d    = acc + {{WINDOW_BITS{1'b0}}, mis};
                sample_d = sample_cnt + CNT_ONE;
                if (sample_d == WINDOW_LEN) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                count_d = acc;
                spin_d  = (acc < HALF_LEN);
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spin_phase_sampler.sv
// Scoreboard bench for spin_phase_sampler (WINDOW_BITS=4, SETTLE_CYCLES=4, SYNC_STAGES=2).
`timescale 1ns/1ps
module tb_spin_phase_sampler;

    localparam int W   = 4;
    localparam int S   = 4;
    localparam int SY  = 2;
    localparam int N   = 1 << W;
`ifdef SAMPLER_GLITCH_FILTER_EN
    localparam int LAT = S + N + 3;
`else
    localparam int LAT = S + N + 1;
`endif
    // Input cycles (relative to the start edge) that land in the sample window.
    localparam int WLO = S + 1 - SY;
    localparam int WHI = S + N - SY;

    logic         clk = 1'b0;
    logic         ising_rstn = 1'b1;
    logic         start = 1'b0;
    logic         sin_ref = 1'b0;
    logic         sin_cell = 1'b0;
    logic         busy;
    logic         valid;
    logic         spin;
    logic [W:0]   mismatch_count;

    typedef struct {
        int cnt;
        int spn;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cnt = 0;
    logic prev_valid = 1'b0;

    spin_phase_sampler #(
        .WINDOW_BITS(W),
        .SETTLE_CYCLES(S),
        .SYNC_STAGES(SY)
    ) dut (
        .clk(clk),
        .ising_rstn(ising_rstn),
        .start(start),
        .sin_ref(sin_ref),
        .sin_cell(sin_cell),
        .busy(busy),
        .valid(valid),
        .spin(spin),
        .mismatch_count(mismatch_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Expected disagreement count from the per-cycle input patterns.
    function automatic int model_count(input logic [63:0] rp, input logic [63:0] cp);
        int c = 0;
`ifdef SAMPLER_GLITCH_FILTER_EN
        for (int e = S + 3; e <= S + N + 2; e++)
            c += int'(maj(rp[e-SY], rp[e-SY-1], rp[e-SY-2]) ^ maj(cp[e-SY], cp[e-SY-1], cp[e-SY-2]));
`else
        for (int j = WLO; j <= WHI; j++)
            c += int'(rp[j] ^ cp[j]);
`endif
        return c;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (ising_rstn && valid) begin
            if (prev_valid) check_eq("valid_pulse_width", 2, 1);
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("valid_cycle", cyc, e.cyc);
                check_eq("mismatch_count", int'(mismatch_count), e.cnt);
                check_eq("spin", int'(spin), e.spn);
                last_cnt = e.cnt;
            end
        end
        prev_valid = valid;
    end

    task automatic measure(input logic [63:0] rp, input logic [63:0] cp, input bit extra);
        exp_t e;
        int   c;
        c = model_count(rp, cp);
        @(posedge clk); #1;
        start = 1'b1;
        sin_ref = rp[0];
        sin_cell = cp[0];
        @(posedge clk); #1;
        e.cnt = c;
        e.spn = (c < N / 2) ? 1 : 0;
        e.cyc = cyc + LAT;
        sb.push_back(e);
        check_eq("busy_after_start", int'(busy), 1);
        check_eq("hold_count", int'(mismatch_count), last_cnt);
        for (int j = 1; j <= LAT + 4; j++) begin
            start = extra && (j == 5 || j == 12 || j == LAT);
            sin_ref = rp[j];
            sin_cell = cp[j];
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq("valid_seen", sb.size(), 0);
        check_eq("busy_idle", int'(busy), 0);
        while (sb.size() != 0) void'(sb.pop_front());
    endtask

    initial begin
        logic [63:0] rp;
        logic [63:0] cp;

        #3 ising_rstn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            sin_ref = i[0];
            sin_cell = ~i[1];
            start = i[0];
        end
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_valid", int'(valid), 0);
        check_eq("rst_spin", int'(spin), 0);
        check_eq("rst_count", int'(mismatch_count), 0);
        @(posedge clk); #1;
        start = 1'b0;
        ising_rstn = 1'b1;
        repeat (3) @(posedge clk);

        for (int j = 0; j < 64; j++) rp[j] = ((j % 6) < 3);
        measure(rp, rp, 1'b0);
        measure(rp, ~rp, 1'b0);
        measure('0, '1, 1'b0);

        rp = '0;
        cp = '0;
        for (int j = WLO; j <= WHI; j++) cp[j] = j[0];
        measure(rp, cp, 1'b0);

        cp[WHI-1] = 1'b0;
        cp[WLO-1] = 1'b1;
        cp[WLO-2] = 1'b1;
        cp[WHI+1] = 1'b1;
        cp[WHI+2] = 1'b1;
        measure(rp, cp, 1'b0);

        cp = '0;
        cp[10] = 1'b1;
        measure(rp, cp, 1'b0);

        for (int k = 0; k < 2; k++) begin
            rp = {$urandom, $urandom};
            cp = {$urandom, $urandom};
            measure(rp, cp, 1'b0);
        end

        for (int j = 0; j < 64; j++) rp[j] = ((j % 6) < 3);
        measure(rp, ~rp, 1'b1);
        repeat (LAT + 5) @(posedge clk);
        #1;
        check_eq("no_restart_busy", int'(busy), 0);

        @(posedge clk); #1;
        start = 1'b1;
        sin_ref = 1'b0;
        sin_cell = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (S + 6) @(posedge clk);
        #1;
        check_eq("abort_busy_before", int'(busy), 1);
        ising_rstn = 1'b0;
        #1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_valid", int'(valid), 0);
        check_eq("abort_spin", int'(spin), 0);
        check_eq("abort_count", int'(mismatch_count), 0);
        last_cnt = 0;
        repeat (2) @(posedge clk);
        #1 ising_rstn = 1'b1;
        repeat (LAT + 10) @(posedge clk);
        #1;
        check_eq("abort_idle_busy", int'(busy), 0);
        check_eq("abort_no_valid", sb.size(), 0);

        measure(rp, ~rp, 1'b0);
        measure(rp, rp, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
